// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: default widths, stage register layout and bubble constant for pipe_ctrl_unit
package pipe_ctrl_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W = 8;
  localparam int DEF_REG_AW = 3;
  typedef struct packed {
    logic valid;
    logic [DEF_OPC_W-1:0] opcode;
    logic [DEF_DATA_W-1:0] operand;
    logic [DEF_DATA_W-1:0] npc;
    logic [DEF_REG_AW-1:0] dst_reg;
    logic writes;
    logic is_load;
  } stage_t;
  localparam stage_t BUBBLE = '0;
endpackage

// File: rtl/pipe_hazard_det.sv
// pipe_hazard_det: RAW hazard, stall and E->D forward select; PIPE_CTRL_FORWARD_EN stalls only on load-use
module pipe_hazard_det #(
  parameter int REG_AW = 3
) (
  input  logic              d_valid,
  input  logic              d_uses_src,
  input  logic [REG_AW-1:0] d_src_reg,
  input  logic              e_valid,
  input  logic              e_writes,
  input  logic              e_is_load,
  input  logic [REG_AW-1:0] e_dst_reg,
  input  logic              hold,
  output logic              stall,
  output logic              d_fwd
);
  logic hz;
  assign hz = d_valid & d_uses_src & e_valid & e_writes & (d_src_reg == e_dst_reg);
`ifdef PIPE_CTRL_FORWARD_EN
  assign stall = hz & e_is_load;
  assign d_fwd = hz & ~e_is_load & ~hold;
`else
  logic unused_fwd_in;
  assign unused_fwd_in = e_is_load ^ hold;
  assign stall = hz;
  assign d_fwd = 1'b0;
`endif
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: 3-stage F/D/E sequencer with PC, hazard stall, branch flush and hold (PIPE_CTRL_FORWARD_EN enables forwarding)
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [OPC_W-1:0]  imem_opc,
  input  logic [DATA_W-1:0] imem_opr,
  input  logic              hold,
  output logic              d_valid,
  output logic [OPC_W-1:0]  d_opcode,
  input  logic [REG_AW-1:0] d_src_reg,
  input  logic              d_uses_src,
  input  logic [REG_AW-1:0] d_dst_reg,
  input  logic              d_writes,
  input  logic              d_is_load,
  output logic              d_fwd,
  output logic              e_valid,
  output logic [OPC_W-1:0]  e_opcode,
  output logic [DATA_W-1:0] e_operand,
  output logic [DATA_W-1:0] e_npc,
  output logic [REG_AW-1:0] e_dst_reg,
  output logic              e_we,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  output logic              stall
);
  typedef struct packed {
    logic valid;
    logic [OPC_W-1:0] opcode;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] npc;
    logic [REG_AW-1:0] dst_reg;
    logic writes;
    logic is_load;
  } stg_t;
  logic [DATA_W-1:0] pc_q, pc_d, d_operand_q, d_operand_d, d_npc_q, d_npc_d;
  logic [OPC_W-1:0] d_opcode_q, d_opcode_d;
  logic d_valid_q, d_valid_d, flush;
  stg_t e_q, e_d;
  pipe_hazard_det #(.REG_AW(REG_AW)) u_hazard (
    .d_valid(d_valid_q),
    .d_uses_src(d_uses_src),
    .d_src_reg(d_src_reg),
    .e_valid(e_q.valid),
    .e_writes(e_q.writes),
    .e_is_load(e_q.is_load),
    .e_dst_reg(e_q.dst_reg),
    .hold(hold),
    .stall(stall),
    .d_fwd(d_fwd)
  );
  assign flush = e_q.valid & br_taken & ~hold;
  always_comb begin
    pc_d = pc_q;
    d_valid_d = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_operand_d = d_operand_q;
    d_npc_d = d_npc_q;
    e_d = e_q;
    if (flush) begin
      pc_d = br_target;
      d_valid_d = 1'b0;
      d_opcode_d = '0;
      d_operand_d = '0;
      d_npc_d = '0;
      e_d = '0;
    end else if (!hold && stall) begin
      e_d = '0;
    end else if (!hold) begin
      pc_d = pc_q + 1'b1;
      d_valid_d = 1'b1;
      d_opcode_d = imem_opc;
      d_operand_d = imem_opr;
      d_npc_d = pc_q + 1'b1;
      e_d = '{valid: d_valid_q, opcode: d_opcode_q, operand: d_operand_q, npc: d_npc_q,
              dst_reg: d_dst_reg, writes: d_writes, is_load: d_is_load};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      d_valid_q <= 1'b0;
      d_opcode_q <= '0;
      d_operand_q <= '0;
      d_npc_q <= '0;
      e_q <= '0;
    end else begin
      pc_q <= pc_d;
      d_valid_q <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_operand_q <= d_operand_d;
      d_npc_q <= d_npc_d;
      e_q <= e_d;
    end
  end
  assign imem_addr = pc_q;
  assign d_valid = d_valid_q;
  assign d_opcode = d_opcode_q;
  assign e_valid = e_q.valid;
  assign e_opcode = e_q.opcode;
  assign e_operand = e_q.operand;
  assign e_npc = e_q.npc;
  assign e_dst_reg = e_q.dst_reg;
  assign e_we = e_q.valid & e_q.writes & ~hold;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench, per-cycle expected pipeline state queued at drive time and checked after the edge
module tb_pipe_ctrl_unit;
`ifdef PIPE_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst, hold, br_taken;
  logic [7:0] imem_addr, imem_opc, imem_opr, br_target;
  logic d_valid, d_fwd, e_valid, e_we, stall, d_uses_src, d_writes, d_is_load;
  logic [7:0] d_opcode, e_opcode, e_operand, e_npc;
  logic [2:0] d_src_reg, d_dst_reg, e_dst_reg;
  logic [7:0] imem [256];
  typedef struct packed {
    logic [7:0] pc;
    logic dv;
    logic [7:0] dop, dopr, dnpc;
    logic ev;
    logic [7:0] eop, eopr, enpc;
    logic [2:0] edst;
    logic ew, eld;
  } st_t;
  st_t m;
  st_t sb[$];
  bit known = 1'b0;
  int n_tests = 0, n_fail = 0, since_br = 99;
  always #5 clk = ~clk;
  assign imem_opc = imem[imem_addr];
  assign imem_opr = imem_addr ^ 8'hA5;
  assign d_src_reg = d_opcode[5:3];
  assign d_uses_src = d_opcode[6];
  assign d_dst_reg = d_opcode[2:0];
  assign d_writes = d_opcode[7];
  assign d_is_load = d_opcode[7] & ~d_opcode[6];
  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_opc(imem_opc), .imem_opr(imem_opr),
    .hold(hold), .d_valid(d_valid), .d_opcode(d_opcode), .d_src_reg(d_src_reg),
    .d_uses_src(d_uses_src), .d_dst_reg(d_dst_reg), .d_writes(d_writes), .d_is_load(d_is_load),
    .d_fwd(d_fwd), .e_valid(e_valid), .e_opcode(e_opcode), .e_operand(e_operand), .e_npc(e_npc),
    .e_dst_reg(e_dst_reg), .e_we(e_we), .br_taken(br_taken), .br_target(br_target), .stall(stall)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic m_hz(st_t s);
    return s.dv && s.dop[6] && s.ev && s.ew && (s.dop[5:3] == s.edst);
  endfunction
  function automatic logic m_stall(st_t s);
    return m_hz(s) && (!FWD || s.eld);
  endfunction
  function automatic st_t m_next(st_t s, logic r, logic h, logic bt, logic [7:0] tg);
    st_t n = s;
    if (r) return '0;
    if (h) return s;
    if (s.ev && bt) begin
      n = '0;
      n.pc = tg;
      return n;
    end
    n.ev = 1'b0; n.eop = '0; n.eopr = '0; n.enpc = '0; n.edst = '0; n.ew = 1'b0; n.eld = 1'b0;
    if (m_stall(s)) return n;
    n.ev = s.dv; n.eop = s.dop; n.eopr = s.dopr; n.enpc = s.dnpc;
    n.edst = s.dop[2:0]; n.ew = s.dop[7]; n.eld = s.dop[7] & ~s.dop[6];
    n.dv = 1'b1; n.dop = imem[s.pc]; n.dopr = s.pc ^ 8'hA5; n.dnpc = s.pc + 8'd1;
    n.pc = s.pc + 8'd1;
    return n;
  endfunction
  task automatic cyc(input logic r, input logic h, input logic bt, input logic [7:0] tg);
    rst = r; hold = h; br_taken = bt; br_target = tg;
    #1;
    if (known) begin
      chk("stall", stall, m_stall(m));
      chk("d_fwd", d_fwd, FWD && m_hz(m) && !m.eld && !h);
      chk("e_we", e_we, m.ev && m.ew && !h);
      if (h) chk("hold_we", e_we, 1'b0);
      if (!h && m.dv && m.ev && m.dop == 8'h58 && m.eop == 8'hC3) begin
        chk("raw_stall", stall, !FWD);
        chk("raw_fwd", d_fwd, FWD);
      end
      if (!h && m.dv && m.ev && m.dop == 8'h68 && m.eop == 8'h85) begin
        chk("lu_stall", stall, 1'b1);
        chk("lu_fwd", d_fwd, 1'b0);
      end
      if (!h && m.dv && m.ev && m.dop == 8'h48 && m.eop == 8'h81) chk("br_stall", stall, 1'b1);
    end
    sb.push_back(m_next(m, r, h, bt, tg));
    @(posedge clk);
    #1;
    m = sb.pop_front();
    known = 1'b1;
    chk("imem_addr", imem_addr, m.pc);
    chk("d_valid", d_valid, m.dv);
    chk("d_opcode", d_opcode, m.dop);
    chk("e_valid", e_valid, m.ev);
    chk("e_opcode", e_opcode, m.eop);
    chk("e_operand", e_operand, m.eopr);
    chk("e_npc", e_npc, m.enpc);
    chk("e_dst_reg", e_dst_reg, m.edst);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic bt, br40;
      logic [7:0] pc_b;
      bt = m.ev && (m.eop == 8'h20 || m.eop == 8'h81);
      br40 = m.ev && m.eop == 8'h20;
      pc_b = m.pc;
      cyc(1'b0, 1'b0, bt, br40 ? 8'h40 : 8'hFD);
      since_br++;
      if (br40) begin
        chk("br_pc", imem_addr, 8'h40);
        chk("br_dv", d_valid, 1'b0);
        chk("br_ev", e_valid, 1'b0);
        since_br = 0;
      end
      if (since_br == 2) begin
        chk("tgt_in_e_v", e_valid, 1'b1);
        chk("tgt_in_e_op", e_opcode, 8'h30);
      end
      if (pc_b == 8'hFF && !bt) chk("pc_wrap", imem_addr, 8'h00);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'h10; imem[1] = 8'h11; imem[2] = 8'h12; imem[3] = 8'h13;
    imem[4] = 8'hC3; imem[5] = 8'h58; imem[6] = 8'h85; imem[7] = 8'h68; imem[8] = 8'h20;
    imem[8'h40] = 8'h30; imem[8'h41] = 8'h81; imem[8'h42] = 8'h48;
    m = '0;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_dv", d_valid, 1'b0);
    chk("rst_ev", e_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd", d_fwd, 1'b0);
    chk("rst_we", e_we, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, i == 0, 8'h77);
      chk("fetch_addr", imem_addr, i + 1);
      if (i == 1) begin
        chk("c3_e_op", e_opcode, 8'h10);
        chk("c3_e_npc", e_npc, 8'h01);
      end
    end
    run(4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, m.ev, 8'h99);
    run(40);
    for (int i = 0; i < 8 && !(m.dv && m.ev); i++) run(1);
    chk("pre_rst_live", {m.dv, m.ev}, 2'b11);
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    chk("mid_rst_addr", imem_addr, 8'h00);
    chk("mid_rst_dv", d_valid, 1'b0);
    chk("mid_rst_ev", e_valid, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    run(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
